// File: rtl/calc_pkg.sv
// Shared key codes, ALU op encoding, sequencer states and small helpers
// for the calculator keypad sequencer.
package calc_pkg;

    localparam logic [3:0] KEY_ADD    = 4'hA;
    localparam logic [3:0] KEY_SUB    = 4'hB;
    localparam logic [3:0] KEY_MUL    = 4'hC;
    localparam logic [3:0] KEY_DIV    = 4'hD;
    localparam logic [3:0] KEY_EQUALS = 4'hE;
    localparam logic [3:0] KEY_CLEAR  = 4'hF;

    typedef enum logic [1:0] {
        OP_ADD = 2'd0,
        OP_SUB = 2'd1,
        OP_MUL = 2'd2,
        OP_DIV = 2'd3
    } calc_op_t;

    typedef enum logic [2:0] {
        ST_ENTER_A     = 3'd0,
        ST_OP_PENDING  = 3'd1,
        ST_ENTER_B     = 3'd2,
        ST_WAIT_ALU    = 3'd3,
        ST_SHOW_RESULT = 3'd4,
        ST_ERROR       = 3'd5
    } calc_state_t;

    function automatic logic is_digit_key(input logic [3:0] key);
        return key <= 4'd9;
    endfunction

    function automatic logic is_operator_key(input logic [3:0] key);
        return (key >= KEY_ADD) && (key <= KEY_DIV);
    endfunction

    function automatic calc_op_t key_to_op(input logic [3:0] key);
        calc_op_t op;
        case (key)
            KEY_SUB: op = OP_SUB;
            KEY_MUL: op = OP_MUL;
            KEY_DIV: op = OP_DIV;
            default: op = OP_ADD;
        endcase
        return op;
    endfunction

    // Used at elaboration to check that the largest enterable operand fits.
    function automatic longint pow10(input int n);
        longint p;
        p = 1;
        for (int i = 0; i < n; i++) p = p * 10;
        return p;
    endfunction

endpackage

// File: rtl/calc_key_sequencer_if.sv
// ALU request/response bundle between the key sequencer (master) and the ALU (slave).
// Handshake: the master raises alu_start with alu_op/alu_a/alu_b and holds all four
// stable until it samples alu_done=1 on a rising edge; alu_result and alu_error are
// meaningful only in that cycle, and alu_done seen while alu_start=0 carries no result.
interface calc_key_sequencer_if #(
    parameter int WIDTH = 16
);
    logic             alu_start;
    logic [1:0]       alu_op;
    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_done;
    logic [WIDTH-1:0] alu_result;
    logic             alu_error;

    modport master (
        output alu_start, alu_op, alu_a, alu_b,
        input  alu_done, alu_result, alu_error
    );

    modport slave (
        input  alu_start, alu_op, alu_a, alu_b,
        output alu_done, alu_result, alu_error
    );
endinterface

// File: rtl/calc_operand_entry.sv
// One decimal operand register: builds a value digit by digit, can be seeded
// with a single digit or loaded with an ALU result, and tracks digit count.
module calc_operand_entry #(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             load_digit,
    input  logic             set_digit,
    input  logic             load_value,
    input  logic [3:0]       digit,
    input  logic [WIDTH-1:0] value_in,
    output logic [WIDTH-1:0] value,
    output logic             full
);
    localparam int CNT_W = $clog2(MAX_DIGITS + 1);

    logic [CNT_W-1:0] digit_count;
    logic [WIDTH-1:0] digit_ext;
    logic [WIDTH-1:0] value_x10;

    assign digit_ext = {{(WIDTH-4){1'b0}}, digit};
    assign value_x10 = (value << 3) + (value << 1);
    assign full      = (digit_count >= CNT_W'(MAX_DIGITS));

    // Value and digit count; leading zeros on an empty value are not counted.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            value       <= '0;
            digit_count <= '0;
        end else if (load_value) begin
            value       <= value_in;
            digit_count <= '0;
        end else if (set_digit) begin
            value       <= digit_ext;
            digit_count <= CNT_W'(1);
        end else if (load_digit) begin
            if (!((value == '0) && (digit == 4'd0))) begin
                value       <= value_x10 + digit_ext;
                digit_count <= digit_count + CNT_W'(1);
            end
        end
    end
endmodule

// File: rtl/calc_key_sequencer.sv
// Keypad sequencer: turns key strobes into operands and operators, issues
// operations to the ALU, handles chaining, repeat-equals, errors and clear.
module calc_key_sequencer
    import calc_pkg::*;
#(
    parameter int WIDTH      = 16,
    parameter int MAX_DIGITS = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [3:0]           button,
    input  logic                 is_pressed_next,
    calc_key_sequencer_if.master alu,
    output logic [WIDTH-1:0]     display_value,
    output logic                 error,
    output logic                 busy,
    output logic                 key_ignored,
    output calc_state_t          state_dbg
);
    localparam longint DIGIT_MAX = pow10(MAX_DIGITS) - 1;
    localparam longint VALUE_MAX = (longint'(1) << (WIDTH - 1)) - 1;

    if (DIGIT_MAX > VALUE_MAX) begin : g_width_check
        $error("calc_key_sequencer: MAX_DIGITS digits do not fit in signed WIDTH");
    end

    calc_state_t state, state_next;
    calc_op_t    op, pending_op;
    logic        chain;

    logic key_digit, key_oper, key_equals, key_clear;
    logic a_load_digit, a_set_digit, a_load_value, b_load_digit, b_set_digit;
    logic entry_clear, drop_key;
    logic a_full, b_full;
    logic [WIDTH-1:0] acc_value, opnd_value;

    assign key_digit  = is_pressed_next && is_digit_key(button);
    assign key_oper   = is_pressed_next && is_operator_key(button);
    assign key_equals = is_pressed_next && (button == KEY_EQUALS);
    assign key_clear  = is_pressed_next && (button == KEY_CLEAR);

    calc_operand_entry #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) u_acc (
        .clock      (clock),
        .reset      (reset),
        .clear      (entry_clear),
        .load_digit (a_load_digit),
        .set_digit  (a_set_digit),
        .load_value (a_load_value),
        .digit      (button),
        .value_in   (alu.alu_result),
        .value      (acc_value),
        .full       (a_full)
    );

    calc_operand_entry #(.WIDTH(WIDTH), .MAX_DIGITS(MAX_DIGITS)) u_opnd (
        .clock      (clock),
        .reset      (reset),
        .clear      (entry_clear),
        .load_digit (b_load_digit),
        .set_digit  (b_set_digit),
        .load_value (1'b0),
        .digit      (button),
        .value_in   ('0),
        .value      (opnd_value),
        .full       (b_full)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= ST_ENTER_A;
        else       state <= state_next;
    end

    // Next-state logic; clear overrides everything, including a same-cycle alu_done.
    always_comb begin
        state_next = state;
        if (key_clear) begin
            state_next = ST_ENTER_A;
        end else begin
            case (state)
                ST_ENTER_A:    if (key_oper) state_next = ST_OP_PENDING;
                ST_OP_PENDING: if (key_digit) state_next = ST_ENTER_B;
                ST_ENTER_B:    if (key_oper || key_equals) state_next = ST_WAIT_ALU;
                ST_WAIT_ALU: begin
                    if (alu.alu_done) begin
                        if (alu.alu_error) state_next = ST_ERROR;
                        else if (chain)    state_next = ST_OP_PENDING;
                        else               state_next = ST_SHOW_RESULT;
                    end
                end
                ST_SHOW_RESULT: begin
                    if (key_digit)       state_next = ST_ENTER_A;
                    else if (key_oper)   state_next = ST_OP_PENDING;
                    else if (key_equals) state_next = ST_WAIT_ALU;
                end
                ST_ERROR:      state_next = ST_ERROR;
                default:       state_next = ST_ENTER_A;
            endcase
        end
    end

    // Outputs and operand-register controls derived from state and the current key.
    always_comb begin
        a_load_digit = 1'b0;
        a_set_digit  = 1'b0;
        a_load_value = 1'b0;
        b_load_digit = 1'b0;
        b_set_digit  = 1'b0;
        entry_clear  = 1'b0;
        drop_key     = 1'b0;
        case (state)
            ST_ENTER_B, ST_WAIT_ALU: display_value = opnd_value;
            ST_ERROR:                display_value = '0;
            default:                 display_value = acc_value;
        endcase
        if (key_clear) begin
            entry_clear = 1'b1;
        end else begin
            case (state)
                ST_ENTER_A: begin
                    if (key_digit) begin
                        if (a_full) drop_key = 1'b1;
                        else        a_load_digit = 1'b1;
                    end
                    if (key_equals) drop_key = 1'b1;
                end
                ST_OP_PENDING: begin
                    if (key_digit)  b_set_digit = 1'b1;
                    if (key_equals) drop_key = 1'b1;
                end
                ST_ENTER_B: begin
                    if (key_digit) begin
                        if (b_full) drop_key = 1'b1;
                        else        b_load_digit = 1'b1;
                    end
                end
                ST_WAIT_ALU: begin
                    if (is_pressed_next) drop_key = 1'b1;
                    if (alu.alu_done && !alu.alu_error) a_load_value = 1'b1;
                end
                ST_SHOW_RESULT: begin
                    if (key_digit) a_set_digit = 1'b1;
                end
                ST_ERROR: begin
                    if (is_pressed_next) drop_key = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Operator registers: current op, the op queued by chaining, and the chain flag.
    always_ff @(posedge clock) begin
        if (reset || key_clear) begin
            op         <= OP_ADD;
            pending_op <= OP_ADD;
            chain      <= 1'b0;
        end else begin
            case (state)
                ST_ENTER_A, ST_OP_PENDING: begin
                    if (key_oper) op <= key_to_op(button);
                end
                ST_ENTER_B: begin
                    if (key_oper) begin
                        pending_op <= key_to_op(button);
                        chain      <= 1'b1;
                    end else if (key_equals) begin
                        chain <= 1'b0;
                    end
                end
                ST_WAIT_ALU: begin
                    if (alu.alu_done && !alu.alu_error && chain) op <= pending_op;
                end
                ST_SHOW_RESULT: begin
                    if (key_oper)        op    <= key_to_op(button);
                    else if (key_equals) chain <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // Dropped-key pulse, one cycle after the strobe.
    always_ff @(posedge clock) begin
        if (reset) key_ignored <= 1'b0;
        else       key_ignored <= drop_key;
    end

    assign alu.alu_start = (state == ST_WAIT_ALU);
    assign alu.alu_op    = op;
    assign alu.alu_a     = acc_value;
    assign alu.alu_b     = opnd_value;
    assign busy          = (state == ST_WAIT_ALU);
    assign error         = (state == ST_ERROR);
    assign state_dbg     = state;
endmodule

// File: tb/tb_calc_key_sequencer.sv
// Directed bench for calc_key_sequencer with a hand-driven ALU responder.
module tb_calc_key_sequencer;
    import calc_pkg::*;

    logic               clock;
    logic               reset;
    logic [3:0]         button;
    logic               is_pressed_next;
    logic signed [15:0] display_value;
    logic               error;
    logic               busy;
    logic               key_ignored;
    calc_state_t        state_dbg;
    int                 n_pass;
    int                 n_total;

    calc_key_sequencer_if #(.WIDTH(16)) alu_bus ();

    calc_key_sequencer #(.WIDTH(16), .MAX_DIGITS(4)) dut (
        .clock           (clock),
        .reset           (reset),
        .button          (button),
        .is_pressed_next (is_pressed_next),
        .alu             (alu_bus.master),
        .display_value   (display_value),
        .error           (error),
        .busy            (busy),
        .key_ignored     (key_ignored),
        .state_dbg       (state_dbg)
    );

    // Clock.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // One-cycle key strobe; called and returns on a falling edge.
    task automatic press(input logic [3:0] k);
        button = k;
        is_pressed_next = 1'b1;
        @(negedge clock);
        is_pressed_next = 1'b0;
    endtask

    // ALU responder: checks the request, answers after lat cycles from start rise.
    task automatic alu_serve(input logic signed [15:0] ea, input logic signed [15:0] eb,
                             input logic [1:0] eop, input int lat,
                             input logic signed [15:0] res, input logic err, input string tag);
        n_total++;
        if (alu_bus.alu_start !== 1'b1)
            $display("FAIL %s_start got %b want 1", tag, alu_bus.alu_start);
        else n_pass++;
        n_total++;
        if (alu_bus.alu_a !== ea || alu_bus.alu_b !== eb || alu_bus.alu_op !== eop)
            $display("FAIL %s_operands got a=%0d b=%0d op=%0d want a=%0d b=%0d op=%0d", tag,
                     $signed(alu_bus.alu_a), $signed(alu_bus.alu_b), alu_bus.alu_op, ea, eb, eop);
        else n_pass++;
        for (int i = 1; i < lat; i++) @(negedge clock);
        n_total++;
        if (alu_bus.alu_start !== 1'b1 || busy !== 1'b1 || alu_bus.alu_a !== ea)
            $display("FAIL %s_hold got start=%b busy=%b a=%0d want 1 1 %0d", tag,
                     alu_bus.alu_start, busy, $signed(alu_bus.alu_a), ea);
        else n_pass++;
        alu_bus.alu_done   = 1'b1;
        alu_bus.alu_result = res;
        alu_bus.alu_error  = err;
        @(negedge clock);
        alu_bus.alu_done  = 1'b0;
        alu_bus.alu_error = 1'b0;
        n_total++;
        if (alu_bus.alu_start !== 1'b0 || busy !== 1'b0)
            $display("FAIL %s_drop got start=%b busy=%b want 0 0", tag, alu_bus.alu_start, busy);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        button = 4'd0;
        is_pressed_next = 1'b0;
        alu_bus.alu_done = 1'b0;
        alu_bus.alu_result = '0;
        alu_bus.alu_error = 1'b0;
        repeat (2) @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        n_total++;
        if (alu_bus.alu_start !== 1'b0 || alu_bus.alu_op !== 2'd0 || alu_bus.alu_a !== 16'd0 || alu_bus.alu_b !== 16'd0)
            $display("FAIL reset_alu got start=%b op=%0d a=%0d b=%0d want 0 0 0 0",
                     alu_bus.alu_start, alu_bus.alu_op, alu_bus.alu_a, alu_bus.alu_b);
        else n_pass++;
        n_total++;
        if (display_value !== 16'sd0 || error !== 1'b0 || busy !== 1'b0 || key_ignored !== 1'b0)
            $display("FAIL reset_outputs got disp=%0d err=%b busy=%b ign=%b want 0 0 0 0",
                     display_value, error, busy, key_ignored);
        else n_pass++;
        n_total++;
        if (state_dbg !== ST_ENTER_A)
            $display("FAIL reset_state got %0d want %0d", state_dbg, ST_ENTER_A);
        else n_pass++;
    endtask

    task automatic test_basic();
        press(4'd1);
        press(4'd2);
        n_total++;
        if (display_value !== 16'sd12) $display("FAIL basic_entry got %0d want 12", display_value);
        else n_pass++;
        press(KEY_ADD);
        n_total++;
        if (state_dbg !== ST_OP_PENDING || display_value !== 16'sd12)
            $display("FAIL basic_op got state=%0d disp=%0d want %0d 12", state_dbg, display_value, ST_OP_PENDING);
        else n_pass++;
        press(4'd3);
        n_total++;
        if (state_dbg !== ST_ENTER_B || display_value !== 16'sd3)
            $display("FAIL basic_b got state=%0d disp=%0d want %0d 3", state_dbg, display_value, ST_ENTER_B);
        else n_pass++;
        press(KEY_EQUALS);
        alu_serve(16'sd12, 16'sd3, 2'd0, 3, 16'sd15, 1'b0, "basic");
        n_total++;
        if (display_value !== 16'sd15 || state_dbg !== ST_SHOW_RESULT)
            $display("FAIL basic_result got disp=%0d state=%0d want 15 %0d", display_value, state_dbg, ST_SHOW_RESULT);
        else n_pass++;
    endtask

    task automatic test_chain();
        press(KEY_CLEAR);
        press(4'd9);
        press(KEY_SUB);
        press(4'd4);
        press(KEY_MUL);
        alu_serve(16'sd9, 16'sd4, 2'd1, 2, 16'sd5, 1'b0, "chain1");
        n_total++;
        if (display_value !== 16'sd5 || state_dbg !== ST_OP_PENDING)
            $display("FAIL chain_mid got disp=%0d state=%0d want 5 %0d", display_value, state_dbg, ST_OP_PENDING);
        else n_pass++;
        press(4'd2);
        press(KEY_EQUALS);
        alu_serve(16'sd5, 16'sd2, 2'd2, 2, 16'sd10, 1'b0, "chain2");
        n_total++;
        if (display_value !== 16'sd10 || state_dbg !== ST_SHOW_RESULT)
            $display("FAIL chain_final got disp=%0d state=%0d want 10 %0d", display_value, state_dbg, ST_SHOW_RESULT);
        else n_pass++;
    endtask

    task automatic test_repeat_equals();
        press(KEY_CLEAR);
        press(4'd2);
        press(KEY_ADD);
        press(4'd3);
        press(KEY_EQUALS);
        alu_serve(16'sd2, 16'sd3, 2'd0, 2, 16'sd5, 1'b0, "rep1");
        n_total++;
        if (display_value !== 16'sd5) $display("FAIL rep1_disp got %0d want 5", display_value);
        else n_pass++;
        press(KEY_EQUALS);
        alu_serve(16'sd5, 16'sd3, 2'd0, 2, 16'sd8, 1'b0, "rep2");
        n_total++;
        if (display_value !== 16'sd8) $display("FAIL rep2_disp got %0d want 8", display_value);
        else n_pass++;
        press(KEY_EQUALS);
        alu_serve(16'sd8, 16'sd3, 2'd0, 2, 16'sd11, 1'b0, "rep3");
        n_total++;
        if (display_value !== 16'sd11) $display("FAIL rep3_disp got %0d want 11", display_value);
        else n_pass++;
    endtask

    task automatic test_digit_limit();
        int pulses;
        logic [3:0] keys [5];
        keys = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        pulses = 0;
        press(KEY_CLEAR);
        for (int i = 0; i < 5; i++) begin
            press(keys[i]);
            if (key_ignored === 1'b1) pulses++;
        end
        @(negedge clock);
        if (key_ignored === 1'b1) pulses++;
        n_total++;
        if (display_value !== 16'sd1234) $display("FAIL limit_value got %0d want 1234", display_value);
        else n_pass++;
        n_total++;
        if (pulses != 1) $display("FAIL limit_ignored got %0d pulses want 1", pulses);
        else n_pass++;
    endtask

    task automatic test_div_zero();
        press(KEY_CLEAR);
        press(4'd7);
        press(KEY_DIV);
        press(4'd0);
        press(KEY_EQUALS);
        alu_serve(16'sd7, 16'sd0, 2'd3, 2, 16'sd0, 1'b1, "div0");
        n_total++;
        if (error !== 1'b1 || display_value !== 16'sd0 || state_dbg !== ST_ERROR)
            $display("FAIL div0_error got err=%b disp=%0d state=%0d want 1 0 %0d", error, display_value, state_dbg, ST_ERROR);
        else n_pass++;
        press(4'd5);
        n_total++;
        if (key_ignored !== 1'b1 || error !== 1'b1)
            $display("FAIL div0_digit_drop got ign=%b err=%b want 1 1", key_ignored, error);
        else n_pass++;
        press(KEY_ADD);
        n_total++;
        if (key_ignored !== 1'b1 || state_dbg !== ST_ERROR)
            $display("FAIL div0_op_drop got ign=%b state=%0d want 1 %0d", key_ignored, state_dbg, ST_ERROR);
        else n_pass++;
        press(KEY_CLEAR);
        n_total++;
        if (error !== 1'b0 || display_value !== 16'sd0 || alu_bus.alu_a !== 16'd0 || state_dbg !== ST_ENTER_A || key_ignored !== 1'b0)
            $display("FAIL div0_clear got err=%b disp=%0d acc=%0d state=%0d ign=%b want 0 0 0 %0d 0",
                     error, display_value, alu_bus.alu_a, state_dbg, key_ignored, ST_ENTER_A);
        else n_pass++;
    endtask

    task automatic test_clear_mid();
        press(4'd4);
        press(KEY_ADD);
        press(4'd5);
        press(KEY_EQUALS);
        n_total++;
        if (alu_bus.alu_start !== 1'b1) $display("FAIL clrmid_start got %b want 1", alu_bus.alu_start);
        else n_pass++;
        @(negedge clock);
        alu_bus.alu_done = 1'b1;
        alu_bus.alu_result = 16'sd9;
        press(KEY_CLEAR);
        alu_bus.alu_done = 1'b0;
        n_total++;
        if (alu_bus.alu_start !== 1'b0 || state_dbg !== ST_ENTER_A || display_value !== 16'sd0)
            $display("FAIL clrmid_clear got start=%b state=%0d disp=%0d want 0 %0d 0",
                     alu_bus.alu_start, state_dbg, display_value, ST_ENTER_A);
        else n_pass++;
        press(KEY_EQUALS);
        n_total++;
        if (key_ignored !== 1'b1 || alu_bus.alu_start !== 1'b0 || display_value !== 16'sd0)
            $display("FAIL clrmid_after got ign=%b start=%b disp=%0d want 1 0 0",
                     key_ignored, alu_bus.alu_start, display_value);
        else n_pass++;
    endtask

    task automatic test_negative();
        press(KEY_CLEAR);
        press(4'd3);
        press(KEY_SUB);
        press(4'd8);
        press(KEY_EQUALS);
        press(4'd1);
        n_total++;
        if (key_ignored !== 1'b1 || display_value !== 16'sd8 || busy !== 1'b1)
            $display("FAIL neg_wait_drop got ign=%b disp=%0d busy=%b want 1 8 1", key_ignored, display_value, busy);
        else n_pass++;
        alu_serve(16'sd3, 16'sd8, 2'd1, 2, -16'sd5, 1'b0, "neg1");
        n_total++;
        if (display_value !== -16'sd5) $display("FAIL neg_result got %0d want -5", display_value);
        else n_pass++;
        press(KEY_ADD);
        n_total++;
        if (display_value !== -16'sd5 || state_dbg !== ST_OP_PENDING)
            $display("FAIL neg_retain got disp=%0d state=%0d want -5 %0d", display_value, state_dbg, ST_OP_PENDING);
        else n_pass++;
        press(4'd2);
        press(KEY_EQUALS);
        alu_serve(-16'sd5, 16'sd2, 2'd0, 2, -16'sd3, 1'b0, "neg2");
        press(4'd7);
        n_total++;
        if (display_value !== 16'sd7 || state_dbg !== ST_ENTER_A)
            $display("FAIL neg_fresh got disp=%0d state=%0d want 7 %0d", display_value, state_dbg, ST_ENTER_A);
        else n_pass++;
    endtask

    // Test sequence and summary.
    initial begin
        n_pass = 0;
        n_total = 0;
        test_reset();
        test_basic();
        test_chain();
        test_repeat_equals();
        test_digit_limit();
        test_div_zero();
        test_clear_mid();
        test_negative();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/calc_key_sequencer.md
# calc_key_sequencer

Parametrised keypad sequencer for the calculator, successor to the fixed-width control unit. It consumes one key strobe at a time, builds signed operands digit by digit, and issues operations to an external ALU over a start/done handshake. It supports operator chaining, repeat-equals and an error state, and it drives the value the display path renders. It sits between the keypad debouncer/encoder and the ALU/display blocks.

## Interface
- WIDTH, 16: operand/result width, signed two's complement.
- MAX_DIGITS, 4: maximum digits per entered operand. Elaboration check: 10^MAX_DIGITS−1 ≤ 2^(WIDTH−1)−1.
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high.
- button  in  4  key code: 0–9 digit, A add, B sub, C mul, D div, E equals, F clear.
- is_pressed_next  in  1  one-cycle strobe: button is valid this cycle.
- alu_start  out  1  operation request; held until done.
- alu_op  out  2  0 add, 1 sub, 2 mul, 3 div.
- alu_a, alu_b  out  WIDTH  operands; stable while alu_start=1.
- alu_done  in  1  result valid this cycle.
- alu_result  in  WIDTH  result.
- alu_error  in  1  overflow or divide-by-zero; qualified by alu_done.
- display_value  out  WIDTH  value to show.
- error  out  1  in ERROR state.
- busy  out  1  in WAIT_ALU.
- key_ignored  out  1  one-cycle pulse when a strobed key is dropped.

## Operation
- Registers: acc (A), opnd (B), op, pending_op, chain flag, digit_count, state.
- Reset: state ENTER_A; acc=opnd=0; op=add; digit_count=0. Outputs after reset: alu_start=0, alu_op=0, alu_a=alu_b=0, display_value=0, error=0, busy=0, key_ignored=0.
- Digit entry: value=value*10+d if digit_count<MAX_DIGITS, else key_ignored. A leading 0 while value==0 leaves digit_count unchanged.
- States and transitions:
  - ENTER_A: digit→accumulate into acc; operator→op, OP_PENDING; equals→ignored.
  - OP_PENDING: digit→opnd=d, count=1, ENTER_B; operator→replace op; equals→ignored.
  - ENTER_B: digit→accumulate into opnd; operator→pending_op=key, chain=1, WAIT_ALU; equals→chain=0, WAIT_ALU.
  - WAIT_ALU: all keys except clear are dropped (key_ignored). On alu_done:
    - alu_error→ERROR.
    - otherwise acc=alu_result; chain ? op=pending_op, OP_PENDING : SHOW_RESULT.
  - SHOW_RESULT: digit→acc=d, count=1, ENTER_A; operator→op, OP_PENDING (acc retained); equals→repeat (acc op opnd), WAIT_ALU, chain=0.
  - ERROR: every key except clear is dropped.
- Clear (F), from any state including WAIT_ALU: same register values as reset. alu_start drops next cycle; an alu_done arriving while alu_start=0 is ignored.
- display_value:
  - acc in ENTER_A, OP_PENDING, SHOW_RESULT.
  - opnd in ENTER_B and WAIT_ALU.
  - 0 in ERROR.
- Negative results are legal; entering digits after a result starts a fresh non-negative operand.

## Timing
- is_pressed_next sampled on the rising edge; state, registers and display_value update one cycle after the strobe.
- alu_start rises the cycle after the triggering key, with alu_a=acc, alu_b=opnd and alu_op=op. It stays high until the edge where alu_done=1 is sampled and is low the following cycle. Minimum ALU round trip: 2 cycles from start rise.
- alu_done and a clear strobe in the same cycle: clear wins, and the result is discarded.
- key_ignored pulses in the cycle after the dropped strobe.
- Back-to-back strobes on consecutive cycles are all processed.

## Structure
- Package calc_pkg holds:
  - key codes KEY_ADD..KEY_DIV=4'hA–4'hD, KEY_EQUALS=4'hE, KEY_CLEAR=4'hF (same value as the existing clear definition);
  - op encoding;
  - state enum.
- Sub-module calc_operand_entry:
  - holds value and digit_count;
  - inputs: load_digit, set_digit, clear;
  - times-10 implemented as (v<<3)+(v<<1);
  - instantiated twice, once for acc and once for opnd.

## Test plan
- Keys 1,2,A,3,E with the ALU answering in 3 cycles: alu_a=12, alu_b=3, alu_op=0; display_value=15; state SHOW_RESULT.
- Chaining, keys 9,B,4,C,2,E: first request 9−4; display shows 5 in OP_PENDING; second request 5*2; final display=10.
- Repeat-equals, keys 2,A,3,E,E,E: display_value 5, 8, 11; each E produces exactly one alu_start pulse train.
- Digit limit, MAX_DIGITS=4, keys 1,2,3,4,5: acc=1234; key_ignored pulses once.
- Division by zero, keys 7,D,0,E with alu_error=1: error=1, display_value=0. Keys 5,A are ignored; after F, error=0 and acc=0.
- Clear mid-operation: F strobed during WAIT_ALU in the same cycle as alu_done: alu_start=0 next cycle, state ENTER_A, display_value=0, result discarded.
